// File: rtl/traffic_light_ctrl_p.sv
// Two-way intersection controller: NS/EW phases with all-red clearance, pedestrian green
// shortening, night flashing-yellow mode and a scanned 7-segment countdown of the phase.
module traffic_light_ctrl_p #(
    parameter int unsigned CLK_HZ    = 1000,
    parameter int unsigned GREEN_S   = 30,
    parameter int unsigned YELLOW_S  = 3,
    parameter int unsigned RED_ALL_S = 1,
    parameter int unsigned PED_MIN_S = 10,
    parameter int unsigned NDIG      = 2,
    parameter int unsigned SCAN_DIV  = 2
) (
    input  logic       CLK1K,
    input  logic       nRST,
    input  logic       ped_req,
    input  logic       night,
    output logic [6:0] seg,
    output logic [5:0] dig,
    output logic [7:0] led
);
    localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [2:0] {StNsg, StNsy, StAr1, StEwg, StEwy, StAr2, StFlash} state_e;

    state_e        state_q, state_d;
    logic [2:0]    ped_sync_q, ped_sync_d;
    logic [1:0]    night_sync_q, night_sync_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [6:0]    sec_q, sec_d;
    logic          pend_q, pend_d;
    logic [SW-1:0] scan_cnt_q, scan_cnt_d;
    logic [2:0]    scan_q, scan_d;
    logic [6:0]    seg_q, seg_d;
    logic [5:0]    dig_q, dig_d;
    logic [7:0]    led_q, led_d;

    logic          tick, ped_edge, night_s, green_q, flash_on;
    logic [3:0]    units, tens;

    function automatic logic [6:0] enc7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    always_ff @(posedge CLK1K or negedge nRST) begin
        if (!nRST) begin
            state_q      <= StAr2;
            ped_sync_q   <= '0;
            night_sync_q <= '0;
            presc_q      <= '0;
            sec_q        <= 7'(RED_ALL_S);
            pend_q       <= 1'b0;
            scan_cnt_q   <= '0;
            scan_q       <= '0;
            seg_q        <= 7'h00;
            dig_q        <= 6'h3F;
            led_q        <= 8'h24;
        end else begin
            state_q      <= state_d;
            ped_sync_q   <= ped_sync_d;
            night_sync_q <= night_sync_d;
            presc_q      <= presc_d;
            sec_q        <= sec_d;
            pend_q       <= pend_d;
            scan_cnt_q   <= scan_cnt_d;
            scan_q       <= scan_d;
            seg_q        <= seg_d;
            dig_q        <= dig_d;
            led_q        <= led_d;
        end
    end

    // Phase sequencing, pedestrian clamp and prescaler.
    always_comb begin
        ped_sync_d   = {ped_sync_q[1:0], ped_req};
        night_sync_d = {night_sync_q[0], night};
        ped_edge     = ped_sync_q[1] & ~ped_sync_q[2];
        night_s      = night_sync_q[1];
        tick         = (presc_q == PW'(CLK_HZ - 1));
        presc_d      = tick ? '0 : presc_q + 1'b1;
        green_q      = (state_q == StNsg) || (state_q == StEwg);

        state_d = state_q;
        sec_d   = sec_q;
        pend_d  = pend_q | ped_edge;

        if (tick) begin
            if (state_q == StFlash) begin
                if (!night_s) begin
                    state_d = StAr2;
                end
            end else if (sec_q <= 7'd1) begin
                case (state_q)
                    StNsg:   state_d = StNsy;
                    StNsy:   state_d = StAr1;
                    StAr1:   state_d = StEwg;
                    StEwg:   state_d = StEwy;
                    StEwy:   state_d = StAr2;
                    default: state_d = StNsg;
                endcase
                // A running green always finishes through its yellow before flashing starts.
                if (night_s && !green_q) begin
                    state_d = StFlash;
                end
            end else begin
                sec_d = sec_q - 7'd1;
            end
        end

        if (state_d != state_q) begin
            case (state_d)
                StNsg, StEwg: sec_d = 7'(GREEN_S);
                StNsy, StEwy: sec_d = 7'(YELLOW_S);
                StAr1, StAr2: sec_d = 7'(RED_ALL_S);
                default:      sec_d = 7'd0;
            endcase
            if (green_q) begin
                pend_d = 1'b0;
            end
        end

        if ((state_d == StNsg || state_d == StEwg) && pend_d && (sec_d > 7'(PED_MIN_S))) begin
            sec_d = 7'(PED_MIN_S);
        end
    end

    // Registered outputs follow next-state values so lamps and display change together.
    always_comb begin
        flash_on = (presc_d < PW'(CLK_HZ / 2));
        case (state_d)
            StNsg:   led_d = 8'h21;
            StNsy:   led_d = 8'h22;
            StEwg:   led_d = 8'h0C;
            StEwy:   led_d = 8'h14;
            StFlash: led_d = flash_on ? 8'h92 : 8'h80;
            default: led_d = 8'h24;
        endcase
        led_d[6] = pend_d;

        scan_cnt_d = scan_cnt_q + 1'b1;
        scan_d     = scan_q;
        if (scan_cnt_q == SW'(SCAN_DIV - 1)) begin
            scan_cnt_d = '0;
            scan_d     = (scan_q == 3'(NDIG - 1)) ? 3'd0 : scan_q + 3'd1;
        end

        units = 4'(sec_d % 7'd10);
        tens  = 4'(sec_d / 7'd10);
        dig_d = 6'h3F;
        seg_d = 7'h00;
        if (state_d != StFlash) begin
            dig_d = ~(6'd1 << scan_d);
            if (scan_d == 3'd0) begin
                seg_d = enc7(units);
            end else if (scan_d == 3'd1 && tens != 4'd0) begin
                seg_d = enc7(tens);
            end
        end
    end

    assign seg = seg_q;
    assign dig = dig_q;
    assign led = led_q;

endmodule

// File: tb/tb_traffic_light_ctrl_p.sv
// Directed bench for traffic_light_ctrl_p with a shortened one-second tick so a full
// cycle, pedestrian, night and mid-phase reset scenarios fit in a few thousand clocks.
module tb_traffic_light_ctrl_p;
    localparam int unsigned S = 20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ped_req;
    logic       night;
    logic [6:0] seg;
    logic [5:0] dig;
    logic [7:0] led;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    traffic_light_ctrl_p #(
        .CLK_HZ   (S),
        .GREEN_S  (30),
        .YELLOW_S (3),
        .RED_ALL_S(1),
        .PED_MIN_S(10),
        .NDIG     (4),
        .SCAN_DIV (2)
    ) dut (
        .CLK1K  (clk),
        .nRST   (rst_n),
        .ped_req(ped_req),
        .night  (night),
        .seg    (seg),
        .dig    (dig),
        .led    (led)
    );

    function automatic logic [6:0] enc(input int d);
        case (d)
            0: return 7'h3F;
            1: return 7'h06;
            2: return 7'h5B;
            3: return 7'h4F;
            4: return 7'h66;
            5: return 7'h6D;
            6: return 7'h7D;
            7: return 7'h07;
            8: return 7'h7F;
            9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input int sec, input int pos);
        if (pos == 0) return enc(sec % 10);
        if (pos == 1 && (sec / 10) != 0) return enc(sec / 10);
        return 7'h00;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s at cyc %0d: observed=%02h expected=%02h", tag, cyc, obs, exp);
        end
    endtask

    // Samples on the falling edge; cyc counts rising edges since reset release.
    task automatic adv_to(input int target);
        while (cyc < target) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic chk_led_at(input string tag, input int at, input logic [7:0] exp);
        adv_to(at);
        chk(tag, led, exp);
    endtask

    // Walks n cycles of the digit scan, checking enables and segment data.
    task automatic chk_scan(input int sec, input int n);
        int pos;
        logic [5:0] e_dig;
        for (int i = 0; i < n; i++) begin
            adv_to(cyc + 1);
            pos   = (cyc / 2) % 4;
            e_dig = ~(6'd1 << pos);
            chk("dig", {2'b00, dig}, {2'b00, e_dig});
            chk("seg", {1'b0, seg}, {1'b0, exp_seg(sec, pos)});
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        ped_req = 1'b0;
        night   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_led", led, 8'h24);
        chk("rst_dig", {2'b00, dig}, 8'h3F);
        chk("rst_seg", {1'b0, seg}, 8'h00);
        rst_n = 1'b1;
        cyc   = 0;

        // Normal cycle
        chk_led_at("ar2_hold", 1, 8'h24);
        chk_led_at("ar2_last", S - 1, 8'h24);
        chk_led_at("nsg_entry", S, 8'h21);
        chk_scan(30, 8);
        adv_to(S * 7);
        chk_scan(24, 8);
        adv_to(S * 24);
        chk_scan(7, 8);
        chk_led_at("nsg_last", S * 31 - 1, 8'h21);
        chk_led_at("nsy_entry", S * 31, 8'h22);
        chk_led_at("nsy_last", S * 34 - 1, 8'h22);
        chk_led_at("ar1_entry", S * 34, 8'h24);
        chk_led_at("ar1_last", S * 35 - 1, 8'h24);
        chk_led_at("ewg_entry", S * 35, 8'h0C);
        chk_led_at("ewg_last", S * 65 - 1, 8'h0C);
        chk_led_at("ewy_entry", S * 65, 8'h14);
        chk_led_at("ar2_entry", S * 68, 8'h24);
        chk_led_at("ar2b_last", S * 69 - 1, 8'h24);
        chk_led_at("nsg2_entry", S * 69, 8'h21);

        // Pedestrian request with 25 s left in NS green
        adv_to(S * 74 + 5);
        ped_req = 1'b1;
        adv_to(S * 74 + 6);
        ped_req = 1'b0;
        chk_led_at("ped_sync", S * 74 + 7, 8'h21);
        chk_led_at("ped_set", S * 74 + 8, 8'h61);
        chk_scan(10, 8);
        chk_led_at("ped_nsg_last", S * 84 - 1, 8'h61);
        chk_led_at("ped_nsy_clear", S * 84, 8'h22);

        // Request during yellow carries into the next green
        adv_to(S * 85);
        ped_req = 1'b1;
        adv_to(S * 85 + 1);
        ped_req = 1'b0;
        chk_led_at("ped_nsy_set", S * 85 + 3, 8'h62);
        chk_led_at("ped_ar1", S * 87, 8'h64);
        chk_led_at("ped_ewg", S * 88, 8'h4C);
        chk_scan(10, 8);

        // Night requested mid-EW green: green and yellow finish, then flashing
        adv_to(S * 90);
        night = 1'b1;
        chk_led_at("night_ewg_last", S * 98 - 1, 8'h4C);
        chk_led_at("night_ewy", S * 98, 8'h14);
        chk_led_at("night_ewy_last", S * 101 - 1, 8'h14);
        chk_led_at("flash_on0", S * 101, 8'h92);
        adv_to(S * 101 + 3);
        chk("flash_dig", {2'b00, dig}, 8'h3F);
        chk("flash_seg", {1'b0, seg}, 8'h00);
        chk_led_at("flash_on_end", S * 101 + S / 2 - 1, 8'h92);
        chk_led_at("flash_off0", S * 101 + S / 2, 8'h80);
        chk_led_at("flash_off_end", S * 102 - 1, 8'h80);
        chk_led_at("flash_on1", S * 102, 8'h92);
        chk_led_at("flash_off1", S * 102 + S / 2, 8'h80);
        night = 1'b0;
        chk_led_at("flash_exit_last", S * 103 - 1, 8'h80);
        chk_led_at("day_ar2", S * 103, 8'h24);
        chk_led_at("day_ar2_last", S * 104 - 1, 8'h24);
        chk_led_at("day_nsg", S * 104, 8'h21);
        chk_scan(30, 4);

        // Reset asserted mid-NS yellow with a pending request
        chk_led_at("nsy3", S * 134, 8'h22);
        adv_to(S * 134 + 10);
        ped_req = 1'b1;
        adv_to(S * 134 + 11);
        ped_req = 1'b0;
        chk_led_at("nsy3_ped", S * 134 + 13, 8'h62);
        adv_to(S * 135);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_led", led, 8'h24);
        chk("mid_rst_dig", {2'b00, dig}, 8'h3F);
        chk("mid_rst_seg", {1'b0, seg}, 8'h00);
        repeat (2) @(negedge clk);
        chk("mid_rst_hold", led, 8'h24);
        rst_n = 1'b1;
        cyc   = 0;
        chk_led_at("re_ar2_last", S - 1, 8'h24);
        chk_led_at("re_nsg", S, 8'h21);
        chk_scan(30, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
